// File: rtl/fb_port_arbiter_if.sv
// rtl/fb_port_arbiter_if.sv - framebuffer arbiter bus: scan-out read, dither write, SPRAM side
interface fb_port_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  ram_wen;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [15:0]           drop_count;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
        output rd_data, rd_valid, wr_full, ram_wen, ram_addr, ram_wdata, drop_count
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
        input  rd_data, rd_valid, wr_full, ram_wen, ram_addr, ram_wdata, drop_count
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - SPRAM framebuffer arbiter, reads win, writes queued; FB_ARB_STATS_EN adds drop counter
module fb_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_16mhz,
    input  logic               reset,
    fb_port_arbiter_if.slave   bus
);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  ram_wen_q, ram_wen_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [1:0]            rd_pipe_q, rd_pipe_d;
    logic                  fifo_empty, fifo_full, do_bypass, pop, push;

    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == DEPTH_C);
        pop         = !bus.rd_req && !fifo_empty;
        do_bypass   = !bus.rd_req && fifo_empty && bus.wr_req;
        // A full queue still accepts the new word when the head leaves this cycle.
        push        = bus.wr_req && !do_bypass && (!fifo_full || pop);
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
        rd_pipe_d   = {rd_pipe_q[0], bus.rd_req};
        ram_wen_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (bus.rd_req) begin
            ram_addr_d  = bus.rd_addr;
        end else if (pop) begin
            ram_wen_d   = 1'b1;
            ram_addr_d  = fifo_addr_q[rd_ptr_q];
            ram_wdata_d = fifo_data_q[rd_ptr_q];
        end else if (do_bypass) begin
            ram_wen_d   = 1'b1;
            ram_addr_d  = bus.wr_addr;
            ram_wdata_d = bus.wr_data;
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_pipe_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
            fifo_data_q[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic        drop;
    logic [15:0] drop_count_q;

    assign drop = bus.wr_req && !do_bypass && fifo_full && !pop;

    always_ff @(posedge clk_16mhz) begin
        if (reset) begin
            drop_count_q <= '0;
        end else if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign bus.drop_count = drop_count_q;
`else
    assign bus.drop_count = '0;
`endif

    assign bus.ram_wen   = ram_wen_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.rd_valid  = rd_pipe_q[1];
    assign bus.rd_data   = bus.ram_rdata;
    assign bus.wr_full   = fifo_full;
endmodule
